// File: rtl/lfsr_rng_core.sv
// lfsr_rng_core: parametrised Fibonacci LFSR random-word generator.
// Bits are shifted out one per enabled step and assembled into OUT_BITS-wide
// words that are offered on a valid/ready handshake. The LFSR freezes while
// a finished word waits for the consumer.
// Optional feature macro: LFSR_LOCKUP_RECOVERY_EN. When defined, an all-zero
// state (or an all-zero runtime seed) is replaced by SEED and lockup pulses.
// When undefined, zero is accepted as-is and lockup is tied low.

module lfsr_rng_core #(
  parameter int                WIDTH    = 31,
  parameter logic [WIDTH-1:0]  TAPS     = 31'h48000020,
  parameter logic [WIDTH-1:0]  SEED     = 31'b1000100110101011010111110101011,
  parameter int                OUT_BITS = 8
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                enable,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_in,
  input  logic                rnd_ready,
  output logic                rnd_valid,
  output logic [OUT_BITS-1:0] rnd_data,
  output logic [WIDTH-1:0]    state_out,
  output logic                lockup
);

  // A one-bit counter is kept even for OUT_BITS=1 so the declaration stays legal.
  localparam int CNT_W = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_BITS - 1);

  typedef enum logic {
    FILL  = 1'b0,
    VALID = 1'b1
  } fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OUT_BITS-1:0] data_q, data_d;
  logic [OUT_BITS-1:0] data_shift;
  logic                fb;

`ifdef LFSR_LOCKUP_RECOVERY_EN
  logic lockup_q, lockup_d;
`endif

  assign fb = ^(lfsr_q & TAPS);

  // The word register takes the new feedback bit at its LSB; the first bit of
  // a word ends up at the MSB. A one-bit word simply becomes the feedback bit.
  generate
    if (OUT_BITS == 1) begin : g_one_bit
      assign data_shift = fb;
    end else begin : g_multi_bit
      assign data_shift = {data_q[OUT_BITS-2:0], fb};
    end
  endgenerate

  // Next-state logic: seed_load wins over everything, FILL steps when enabled,
  // VALID waits for the consumer with the LFSR frozen.
  always_comb begin
    fsm_d  = fsm_q;
    lfsr_d = lfsr_q;
    cnt_d  = cnt_q;
    data_d = data_q;
`ifdef LFSR_LOCKUP_RECOVERY_EN
    lockup_d = 1'b0;
`endif
    if (seed_load) begin
      fsm_d = FILL;
      cnt_d = '0;
`ifdef LFSR_LOCKUP_RECOVERY_EN
      if (seed_in == '0) begin
        lfsr_d   = SEED;
        lockup_d = 1'b1;
      end else begin
        lfsr_d = seed_in;
      end
`else
      lfsr_d = seed_in;
`endif
    end else begin
      case (fsm_q)
        FILL: begin
`ifdef LFSR_LOCKUP_RECOVERY_EN
          if (lfsr_q == '0) begin
            lfsr_d   = SEED;
            lockup_d = 1'b1;
          end else
`endif
          if (enable) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], fb};
            data_d = data_shift;
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              fsm_d = VALID;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        VALID: begin
          if (rnd_ready) begin
            fsm_d = FILL;
          end
        end
        default: fsm_d = FILL;
      endcase
    end
  end

  // State registers; reset discards any partial word and reloads SEED.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      fsm_q  <= FILL;
      lfsr_q <= SEED;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

`ifdef LFSR_LOCKUP_RECOVERY_EN
  // One-cycle lockup pulse on the edge after a zero state or zero seed.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      lockup_q <= 1'b0;
    end else begin
      lockup_q <= lockup_d;
    end
  end

  assign lockup = lockup_q;
`else
  assign lockup = 1'b0;
`endif

  assign rnd_valid = (fsm_q == VALID);
  assign rnd_data  = data_q;
  assign state_out = lfsr_q;

endmodule

// File: tb/tb_lfsr_rng_core.sv
// tb_lfsr_rng_core: directed bench for lfsr_rng_core.
// Small instance: WIDTH=4, TAPS=4'b1100, SEED=4'b0001, OUT_BITS=4.
// With OUT_BITS equal to WIDTH the state at each valid point equals the word.
// A second default-parameter instance free-runs for a few hundred words.

module tb_lfsr_rng_core;

  logic       clk_in;
  logic       reset;
  logic       enable;
  logic       seed_load;
  logic [3:0] seed_in;
  logic       rnd_ready;
  logic       rnd_valid;
  logic [3:0] rnd_data;
  logic [3:0] state_out;
  logic       lockup;

  logic        en_def;
  logic        ready_def;
  logic        valid_def;
  logic [7:0]  data_def;
  logic [30:0] state_def;
  logic        lockup_def;

  int checks = 0;
  int errors = 0;

  lfsr_rng_core #(
    .WIDTH   (4),
    .TAPS    (4'b1100),
    .SEED    (4'b0001),
    .OUT_BITS(4)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (enable),
    .seed_load(seed_load),
    .seed_in  (seed_in),
    .rnd_ready(rnd_ready),
    .rnd_valid(rnd_valid),
    .rnd_data (rnd_data),
    .state_out(state_out),
    .lockup   (lockup)
  );

  lfsr_rng_core u_def (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (en_def),
    .seed_load(1'b0),
    .seed_in  (31'd0),
    .rnd_ready(ready_def),
    .rnd_valid(valid_def),
    .rnd_data (data_def),
    .state_out(state_def),
    .lockup   (lockup_def)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    seed_load = 1'b0;
    seed_in   = 4'd0;
    rnd_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Step edges until rnd_valid is seen; edges = -1 when the budget runs out.
  task automatic wait_word(output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rnd_valid) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    seed_load = 1'b0;
    seed_in = 4'd0;
    rnd_ready = 1'b0;
    en_def = 1'b0;
    ready_def = 1'b0;
    #3;
    checks++;
    if (state_out !== 4'b0001) begin errors++; $display("[TB] FAIL reset_state got %b want 0001", state_out); end
    checks++;
    if (rnd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", rnd_valid); end
    checks++;
    if (rnd_data !== 4'h0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", rnd_data); end
    checks++;
    if (lockup !== 1'b0) begin errors++; $display("[TB] FAIL reset_lockup got %b want 0", lockup); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [3:0] exp_w [3];
    int edges;
    exp_w[0] = 4'h3; exp_w[1] = 4'h5; exp_w[2] = 4'hE;
    do_reset();
    enable = 1'b1;
    rnd_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (rnd_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_early_valid got %b want 0", rnd_valid); end
    tick();
    checks++;
    if (rnd_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid_edge4 got %b want 1", rnd_valid); end
    for (int w = 0; w < 3; w++) begin
      if (w > 0) begin
        tick();
        checks++;
        if (rnd_valid !== 1'b0 || state_out !== exp_w[w-1]) begin
          errors++;
          $display("[TB] FAIL stream_transfer_nostep got valid=%b state=%b want valid=0 state=%b", rnd_valid, state_out, exp_w[w-1]);
        end
        wait_word(edges);
        checks++;
        if (edges != 4) begin errors++; $display("[TB] FAIL stream_latency got %0d want 4", edges); end
      end
      checks++;
      if (rnd_data !== exp_w[w]) begin errors++; $display("[TB] FAIL stream_word%0d got %h want %h", w, rnd_data, exp_w[w]); end
      checks++;
      if (state_out !== exp_w[w]) begin errors++; $display("[TB] FAIL stream_state%0d got %b want %b", w, state_out, exp_w[w]); end
    end
  endtask

  task automatic test_backpressure();
    int edges;
    do_reset();
    enable = 1'b1;
    rnd_ready = 1'b0;
    wait_word(edges);
    checks++;
    if (edges != 4) begin errors++; $display("[TB] FAIL bp_first_latency got %0d want 4", edges); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rnd_valid !== 1'b1 || rnd_data !== 4'h3 || state_out !== 4'b0011) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d got valid=%b data=%h state=%b want 1/3/0011", i, rnd_valid, rnd_data, state_out);
      end
    end
    rnd_ready = 1'b1;
    tick();
    checks++;
    if (rnd_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_transfer got valid %b want 0", rnd_valid); end
    wait_word(edges);
    checks++;
    if (edges != 4 || rnd_data !== 4'h5) begin
      errors++;
      $display("[TB] FAIL bp_next_word got edges=%0d data=%h want 4/5", edges, rnd_data);
    end
  endtask

  task automatic test_enable_toggle();
    logic [3:0] exp_w [3];
    int edges;
    exp_w[0] = 4'h3; exp_w[1] = 4'h5; exp_w[2] = 4'hE;
    do_reset();
    rnd_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      edges = 0;
      for (int k = 0; k < 10; k++) begin
        enable = 1'b0;
        tick();
        edges++;
        if (w == 0 && k == 0) begin
          checks++;
          if (state_out !== 4'b0001) begin errors++; $display("[TB] FAIL toggle_hold got %b want 0001", state_out); end
        end
        enable = 1'b1;
        tick();
        edges++;
        if (rnd_valid) break;
      end
      checks++;
      if (edges != 8 || rnd_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL toggle_latency word %0d got edges=%0d valid=%b want 8/1", w, edges, rnd_valid);
      end
      checks++;
      if (rnd_data !== exp_w[w]) begin errors++; $display("[TB] FAIL toggle_word%0d got %h want %h", w, rnd_data, exp_w[w]); end
      enable = 1'b0;
      tick();
    end
  endtask

  task automatic test_seed_load();
    int edges;
    do_reset();
    enable = 1'b1;
    rnd_ready = 1'b1;
    tick(); tick();
    seed_load = 1'b1;
    seed_in = 4'b0001;
    tick();
    seed_load = 1'b0;
    checks++;
    if (state_out !== 4'b0001 || rnd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seed_load_state got state=%b valid=%b want 0001/0", state_out, rnd_valid);
    end
    wait_word(edges);
    checks++;
    if (edges != 4 || rnd_data !== 4'h3) begin
      errors++;
      $display("[TB] FAIL seed_load_word got edges=%0d data=%h want 4/3", edges, rnd_data);
    end
    rnd_ready = 1'b0;
    seed_load = 1'b1;
    seed_in = 4'b0011;
    tick();
    seed_load = 1'b0;
    rnd_ready = 1'b1;
    checks++;
    if (rnd_valid !== 1'b0 || state_out !== 4'b0011) begin
      errors++;
      $display("[TB] FAIL seed_load_in_valid got valid=%b state=%b want 0/0011", rnd_valid, state_out);
    end
    wait_word(edges);
    checks++;
    if (edges != 4 || rnd_data !== 4'h5) begin
      errors++;
      $display("[TB] FAIL seed_load_second got edges=%0d data=%h want 4/5", edges, rnd_data);
    end
  endtask

  task automatic test_zero_seed();
    int edges;
    logic saw_lockup;
    do_reset();
    enable = 1'b1;
    rnd_ready = 1'b1;
    seed_load = 1'b1;
    seed_in = 4'b0000;
    tick();
    seed_load = 1'b0;
`ifdef LFSR_LOCKUP_RECOVERY_EN
    checks++;
    if (state_out !== 4'b0001 || lockup !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_seed_recover got state=%b lockup=%b want 0001/1", state_out, lockup);
    end
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        checks++;
        if (lockup !== 1'b0) begin errors++; $display("[TB] FAIL zero_seed_pulse_len got %b want 0", lockup); end
      end
      if (rnd_valid) begin
        edges = i;
        break;
      end
    end
    checks++;
    if (edges != 4 || rnd_data !== 4'h3) begin
      errors++;
      $display("[TB] FAIL zero_seed_word got edges=%0d data=%h want 4/3", edges, rnd_data);
    end
`else
    checks++;
    if (state_out !== 4'b0000 || lockup !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_seed_stick got state=%b lockup=%b want 0000/0", state_out, lockup);
    end
    saw_lockup = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (w > 0) tick();
      wait_word(edges);
      if (lockup) saw_lockup = 1'b1;
      checks++;
      if (edges != 4 || rnd_data !== 4'h0) begin
        errors++;
        $display("[TB] FAIL zero_seed_word%0d got edges=%0d data=%h want 4/0", w, edges, rnd_data);
      end
    end
    checks++;
    if (saw_lockup !== 1'b0) begin errors++; $display("[TB] FAIL zero_seed_lockup got %b want 0", saw_lockup); end
`endif
  endtask

  task automatic test_async_reset();
    int edges;
    do_reset();
    enable = 1'b1;
    rnd_ready = 1'b0;
    wait_word(edges);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state_out !== 4'b0001 || rnd_valid !== 1'b0 || rnd_data !== 4'h0 || lockup !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got state=%b valid=%b data=%h lockup=%b want 0001/0/0/0", state_out, rnd_valid, rnd_data, lockup);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    bit seen [logic [30:0]];
    int words;
    words = 0;
    checks++;
    if (state_def !== 31'b1000100110101011010111110101011) begin
      errors++;
      $display("[TB] FAIL free_seed got %h want %h", state_def, 31'b1000100110101011010111110101011);
    end
    en_def = 1'b1;
    ready_def = 1'b1;
    for (int c = 0; c < 20000 && words < 600; c++) begin
      tick();
      if (valid_def) begin
        checks++;
        if (state_def == 31'd0 || seen.exists(state_def) || data_def !== state_def[7:0] || lockup_def !== 1'b0) begin
          errors++;
          $display("[TB] FAIL free_word %0d got state=%h data=%h lockup=%b want fresh nonzero state, data=state[7:0], lockup 0",
                   words, state_def, data_def, lockup_def);
        end
        seen[state_def] = 1'b1;
        words++;
      end
    end
    checks++;
    if (words != 600) begin errors++; $display("[TB] FAIL free_count got %0d want 600", words); end
    en_def = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_enable_toggle();
    test_seed_load();
    test_zero_seed();
    test_async_reset();
    test_free_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
